// File: rtl/uart_pkg.sv
// Shared definitions for the configurable UART transmitter.
//   - parity mode encodings as carried on cfg_parity
//   - transmitter FSM state encoding
//   - calc_bps_cnt(): clocks per line bit from clock and baud rates
package uart_pkg;

    localparam logic [1:0] PAR_NONE = 2'b00;
    localparam logic [1:0] PAR_ODD  = 2'b01;
    localparam logic [1:0] PAR_EVEN = 2'b10;
    // 2'b11 is not named: it behaves exactly like PAR_NONE.

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } tx_state_e;

    // Integer division truncates; the caller must choose rates giving >= 2.
    function automatic int calc_bps_cnt(input int clk_freq, input int uart_bps);
        return clk_freq / uart_bps;
    endfunction

    function automatic logic parity_enabled(input logic [1:0] mode);
        return (mode == PAR_ODD) || (mode == PAR_EVEN);
    endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Bit-period counter for the UART transmitter.
// Ports:
//   clk      in  system clock
//   rst_n    in  synchronous active-low reset
//   clr      in  synchronous clear (frame accepted), wins over en
//   en       in  count enable (frame on the line)
//   bit_tick out high for the last clock of each bit period
module uart_baud_tick
    import uart_pkg::*;
#(
    parameter int BPS_CNT = 10
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic bit_tick
);

    localparam int CW = (BPS_CNT > 2) ? $clog2(BPS_CNT) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(BPS_CNT - 1);

    logic [CW-1:0] cnt_q, cnt_d;

    // Gated by en so no tick can leak out while the transmitter is idle.
    assign bit_tick = en && (cnt_q == CNT_LAST);

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en) begin
            // Wrap explicitly at the terminal value; never run past it.
            cnt_d = bit_tick ? '0 : cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    end

endmodule

// File: rtl/uart_tx_cfg.sv
// Configurable UART transmitter: DATA_BITS data bits, runtime parity
// (none/odd/even) and 1 or 2 stop bits, valid/ready request handshake.
// Ports:
//   sys_clk    in  system clock
//   sys_rst_n  in  synchronous active-low reset
//   uart_en    in  frame request (valid), level-sensitive
//   uart_din   in  frame data, sent LSB first
//   cfg_parity in  00 none, 01 odd, 10 even, 11 none
//   cfg_stop2  in  0 one stop bit, 1 two stop bits
//   tx_ready   out request can be accepted this cycle (idle)
//   tx_busy    out frame on the line
//   tx_done    out one-cycle pulse on the last clock of the final stop bit
//   uart_txd   out registered serial line, idle high
module uart_tx_cfg
    import uart_pkg::*;
#(
    parameter int CLK_FREQ  = 50000000,
    parameter int UART_BPS  = 115200,
    parameter int DATA_BITS = 8
) (
    input  logic                 sys_clk,
    input  logic                 sys_rst_n,
    input  logic                 uart_en,
    input  logic [DATA_BITS-1:0] uart_din,
    input  logic [1:0]           cfg_parity,
    input  logic                 cfg_stop2,
    output logic                 tx_ready,
    output logic                 tx_busy,
    output logic                 tx_done,
    output logic                 uart_txd
);

    localparam int BPS_CNT = calc_bps_cnt(CLK_FREQ, UART_BPS);
    localparam int DCW     = $clog2(DATA_BITS);
    localparam logic [DCW-1:0] DATA_LAST = DCW'(DATA_BITS - 1);

    tx_state_e            state_q, state_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic [DCW-1:0]       dcnt_q, dcnt_d;
    logic                 par_en_q, par_en_d;
    logic                 par_bit_q, par_bit_d;
    logic                 stop2_q, stop2_d;
    logic                 stop_cnt_q, stop_cnt_d;
    logic                 txd_q, txd_d;

    logic accept;
    logic bit_tick;
    logic frame_end;

    assign tx_ready = (state_q == ST_IDLE);
    assign tx_busy  = (state_q != ST_IDLE);
    assign accept   = uart_en && tx_ready;
    assign uart_txd = txd_q;
    // A frame cut short by reset must not report completion.
    assign tx_done  = frame_end && sys_rst_n;

    uart_baud_tick #(
        .BPS_CNT (BPS_CNT)
    ) u_baud (
        .clk      (sys_clk),
        .rst_n    (sys_rst_n),
        .clr      (accept),
        .en       (tx_busy),
        .bit_tick (bit_tick)
    );

    // txd_d always carries the level of the bit that starts on the next
    // clock, so the line changes exactly at bit boundaries.
    always_comb begin
        state_d    = state_q;
        shift_d    = shift_q;
        dcnt_d     = dcnt_q;
        par_en_d   = par_en_q;
        par_bit_d  = par_bit_q;
        stop2_d    = stop2_q;
        stop_cnt_d = stop_cnt_q;
        txd_d      = txd_q;
        frame_end  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                txd_d = 1'b1;
                if (accept) begin
                    // Snapshot everything the frame needs; later input
                    // changes cannot disturb it.
                    state_d    = ST_START;
                    shift_d    = uart_din;
                    dcnt_d     = '0;
                    par_en_d   = parity_enabled(cfg_parity);
                    par_bit_d  = (cfg_parity == PAR_ODD) ? ~^uart_din : ^uart_din;
                    stop2_d    = cfg_stop2;
                    stop_cnt_d = 1'b0;
                    txd_d      = 1'b0;
                end
            end

            ST_START: begin
                if (bit_tick) begin
                    state_d = ST_DATA;
                    dcnt_d  = '0;
                    txd_d   = shift_q[0];
                    shift_d = shift_q >> 1;
                end
            end

            ST_DATA: begin
                if (bit_tick) begin
                    if (dcnt_q == DATA_LAST) begin
                        if (par_en_q) begin
                            state_d = ST_PARITY;
                            txd_d   = par_bit_q;
                        end else begin
                            state_d = ST_STOP;
                            txd_d   = 1'b1;
                        end
                    end else begin
                        dcnt_d  = dcnt_q + 1'b1;
                        txd_d   = shift_q[0];
                        shift_d = shift_q >> 1;
                    end
                end
            end

            ST_PARITY: begin
                if (bit_tick) begin
                    state_d = ST_STOP;
                    txd_d   = 1'b1;
                end
            end

            ST_STOP: begin
                txd_d = 1'b1;
                if (bit_tick) begin
                    // Second stop bit: one more full period before idling.
                    if (stop2_q && !stop_cnt_q) begin
                        stop_cnt_d = 1'b1;
                    end else begin
                        state_d   = ST_IDLE;
                        frame_end = 1'b1;
                    end
                end
            end

            default: begin
                state_d = ST_IDLE;
                txd_d   = 1'b1;
            end
        endcase
    end

    always_ff @(posedge sys_clk) begin
        if (!sys_rst_n) begin
            state_q    <= ST_IDLE;
            shift_q    <= '0;
            dcnt_q     <= '0;
            par_en_q   <= 1'b0;
            par_bit_q  <= 1'b0;
            stop2_q    <= 1'b0;
            stop_cnt_q <= 1'b0;
            txd_q      <= 1'b1;
        end else begin
            state_q    <= state_d;
            shift_q    <= shift_d;
            dcnt_q     <= dcnt_d;
            par_en_q   <= par_en_d;
            par_bit_q  <= par_bit_d;
            stop2_q    <= stop2_d;
            stop_cnt_q <= stop_cnt_d;
            txd_q      <= txd_d;
        end
    end

endmodule

// File: tb/tb_uart_tx_cfg.sv
// Self-checking bench for uart_tx_cfg: an 8-bit and a 7-bit instance, each
// compared every cycle against a queue-of-line-levels frame model, plus
// hand-computed literal checks of the directed scenarios.
module tb_uart_tx_cfg;

    localparam int BPS  = 10;
    localparam int HMAX = 16384;

    logic sys_clk = 1'b0;
    logic sys_rst_n = 1'b0;
    always #5 sys_clk = ~sys_clk;

    logic       en8 = 1'b0, st8 = 1'b0;
    logic [7:0] din8 = '0;
    logic [1:0] par8 = '0;
    logic       rdy8, bsy8, dn8, txd8;

    logic       en7 = 1'b0, st7 = 1'b0;
    logic [6:0] din7 = '0;
    logic [1:0] par7 = '0;
    logic       rdy7, bsy7, dn7, txd7;

    uart_tx_cfg #(.CLK_FREQ(50000000), .UART_BPS(5000000), .DATA_BITS(8)) dut8 (
        .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .uart_en(en8), .uart_din(din8),
        .cfg_parity(par8), .cfg_stop2(st8), .tx_ready(rdy8), .tx_busy(bsy8),
        .tx_done(dn8), .uart_txd(txd8));

    uart_tx_cfg #(.CLK_FREQ(50000000), .UART_BPS(5000000), .DATA_BITS(7)) dut7 (
        .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .uart_en(en7), .uart_din(din7),
        .cfg_parity(par7), .cfg_stop2(st7), .tx_ready(rdy7), .tx_busy(bsy7),
        .tx_done(dn7), .uart_txd(txd7));

    int n_chk = 0, n_err = 0;
    int cyc = 0;
    bit chk_on = 1'b0;
    logic hist8 [0:HMAX-1];
    logic hist7 [0:HMAX-1];
    int acc8_cyc = -1, acc7_cyc = -1;
    int done8_count = 0;
    logic q8 [$];
    logic q7 [$];

    always @(posedge sys_clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input int act, input int exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            if (n_err <= 40)
                $display("FAIL %s at cycle %0d: got %0h expected %0h", nm, cyc, act, exp);
        end
    endtask

    // Frame as a list of line bits: start, data LSB first, parity, stops.
    function automatic void build_frame(input logic [8:0] d, input int nb,
                                        input logic [1:0] pm, input logic s2,
                                        output logic [15:0] fb, output int n);
        int ones = 0;
        fb = '0;
        fb[0] = 1'b0;
        for (int i = 0; i < nb; i++) begin
            fb[1+i] = d[i];
            ones += int'(d[i]);
        end
        n = 1 + nb;
        if (pm == 2'b01) begin fb[n] = (ones % 2 == 0); n++; end
        if (pm == 2'b10) begin fb[n] = (ones % 2 == 1); n++; end
        fb[n] = 1'b1; n++;
        if (s2) begin fb[n] = 1'b1; n++; end
    endfunction

    // Bench receiver: sample line bit j mid-period after an accept.
    function automatic logic [15:0] rx(input int sel, input int acc, input int nb);
        logic [15:0] r = '0;
        for (int j = 0; j < nb; j++) begin
            int idx = acc + 6 + j * BPS;
            if (idx >= 0 && idx < HMAX) r[j] = (sel == 8) ? hist8[idx] : hist7[idx];
        end
        return r;
    endfunction

    // Model for the 8-bit instance.
    always @(negedge sys_clk) begin
        logic [15:0] fb;
        int n;
        logic e_txd;
        bit idle;
        idle  = (q8.size() == 0);
        e_txd = idle ? 1'b1 : q8[0];
        if (chk_on) begin
            chk("txd8", int'(txd8), int'(e_txd));
            chk("busy8", int'(bsy8), int'(!idle));
            chk("ready8", int'(rdy8), int'(idle));
            chk("done8", int'(dn8), int'(q8.size() == 1 && sys_rst_n));
        end
        if (cyc < HMAX) hist8[cyc] = txd8;
        if (dn8 === 1'b1) done8_count++;
        if (!idle) void'(q8.pop_front());
        if (!sys_rst_n) q8.delete();
        else if (idle && en8) begin
            build_frame({1'b0, din8}, 8, par8, st8, fb, n);
            for (int j = 0; j < n; j++)
                for (int k = 0; k < BPS; k++) q8.push_back(fb[j]);
            acc8_cyc = cyc;
        end
    end

    // Model for the 7-bit instance.
    always @(negedge sys_clk) begin
        logic [15:0] fb;
        int n;
        logic e_txd;
        bit idle;
        idle  = (q7.size() == 0);
        e_txd = idle ? 1'b1 : q7[0];
        if (chk_on) begin
            chk("txd7", int'(txd7), int'(e_txd));
            chk("busy7", int'(bsy7), int'(!idle));
            chk("ready7", int'(rdy7), int'(idle));
            chk("done7", int'(dn7), int'(q7.size() == 1 && sys_rst_n));
        end
        if (cyc < HMAX) hist7[cyc] = txd7;
        if (!idle) void'(q7.pop_front());
        if (!sys_rst_n) q7.delete();
        else if (idle && en7) begin
            build_frame({2'b00, din7}, 7, par7, st7, fb, n);
            for (int j = 0; j < n; j++)
                for (int k = 0; k < BPS; k++) q7.push_back(fb[j]);
            acc7_cyc = cyc;
        end
    end

    // Returns at the negedge of the tx_done cycle, or flags a timeout.
    task automatic wait_done(input int sel, input int bound, output int dcyc);
        int k = 0;
        dcyc = -1;
        do begin
            @(negedge sys_clk);
            k++;
        end while (!((sel == 8) ? (dn8 === 1'b1) : (dn7 === 1'b1)) && k < bound);
        if ((sel == 8) ? (dn8 === 1'b1) : (dn7 === 1'b1)) dcyc = cyc;
        else chk("done_timeout", 0, 1);
    endtask

    task automatic pulse8(input logic [7:0] d, input logic [1:0] p, input logic s);
        @(posedge sys_clk); #1;
        din8 = d; par8 = p; st8 = s; en8 = 1'b1;
        @(posedge sys_clk); #1;
        en8 = 1'b0;
    endtask

    initial begin
        int d, d1, a1, dc;
        logic [15:0] r;

        @(posedge sys_clk); #1;
        chk_on = 1'b1;
        @(negedge sys_clk);
        chk("rst_txd", int'(txd8), 1);
        chk("rst_ready", int'(rdy8), 1);
        chk("rst_busy", int'(bsy8), 0);
        chk("rst_done", int'(dn8), 0);
        chk("rst_txd7", int'(txd7), 1);
        @(posedge sys_clk); #1;
        sys_rst_n = 1'b1;
        repeat (3) @(posedge sys_clk);

        // 8N1 0x55
        pulse8(8'h55, 2'b00, 1'b0);
        wait_done(8, 200, d);
        chk("t1_latency", d - acc8_cyc, 100);
        chk("t1_ready_in_done", int'(rdy8), 0);
        chk("t1_line", int'(rx(8, acc8_cyc, 10)), 16'h02AA);
        @(negedge sys_clk);
        chk("t1_ready_after", int'(rdy8), 1);
        repeat (3) @(posedge sys_clk);

        // 8E1 0xA7 then 8O1 0xA7
        pulse8(8'hA7, 2'b10, 1'b0);
        wait_done(8, 200, d);
        chk("t2e_latency", d - acc8_cyc, 110);
        r = rx(8, acc8_cyc, 11);
        chk("t2e_parity", int'(r[9]), 1);
        chk("t2e_data", int'(r[8:1]), 8'hA7);
        repeat (3) @(posedge sys_clk);
        pulse8(8'hA7, 2'b01, 1'b0);
        wait_done(8, 200, d);
        r = rx(8, acc8_cyc, 11);
        chk("t2o_parity", int'(r[9]), 0);
        repeat (3) @(posedge sys_clk);

        // 8O2 0x00 with config/data scrambled mid-frame
        pulse8(8'h00, 2'b01, 1'b1);
        repeat (30) @(posedge sys_clk);
        #1 par8 = 2'b00; st8 = 1'b0; din8 = 8'hFF;
        wait_done(8, 200, d);
        chk("t3_latency", d - acc8_cyc, 120);
        chk("t3_line", int'(rx(8, acc8_cyc, 12)), 16'h0E00);
        repeat (3) @(posedge sys_clk);

        // Back-to-back with uart_en held high
        @(posedge sys_clk); #1;
        din8 = 8'h31; par8 = 2'b00; st8 = 1'b0; en8 = 1'b1;
        wait_done(8, 200, d1);
        a1 = acc8_cyc;
        @(posedge sys_clk); #1;
        din8 = 8'h32;
        @(posedge sys_clk); #1;
        en8 = 1'b0;
        wait_done(8, 200, d);
        chk("t4_second_acc", acc8_cyc, d1 + 1);
        chk("t4_gap_high", int'(hist8[d1 + 1]), 1);
        chk("t4_start_low", int'(hist8[d1 + 2]), 0);
        r = rx(8, a1, 10);
        chk("t4_byte1", int'(r[8:1]), 8'h31);
        r = rx(8, acc8_cyc, 10);
        chk("t4_byte2", int'(r[8:1]), 8'h32);
        repeat (3) @(posedge sys_clk);

        // 7-bit instance, 0x7F even parity
        @(posedge sys_clk); #1;
        din7 = 7'h7F; par7 = 2'b10; st7 = 1'b0; en7 = 1'b1;
        @(posedge sys_clk); #1;
        en7 = 1'b0;
        wait_done(7, 200, d);
        chk("t5_latency", d - acc7_cyc, 100);
        chk("t5_line", int'(rx(7, acc7_cyc, 10)), 16'h03FE);
        repeat (3) @(posedge sys_clk);

        // Reset pulse in data bit 3, then a clean 0xC3 frame
        dc = done8_count;
        pulse8(8'h5A, 2'b10, 1'b1);
        while (cyc < acc8_cyc + 46) begin @(posedge sys_clk); #1; end
        sys_rst_n = 1'b0;
        @(posedge sys_clk); #1;
        sys_rst_n = 1'b1;
        @(negedge sys_clk);
        chk("t6_txd", int'(txd8), 1);
        chk("t6_busy", int'(bsy8), 0);
        chk("t6_ready", int'(rdy8), 1);
        repeat (100) @(negedge sys_clk);
        chk("t6_no_done", done8_count, dc);
        pulse8(8'hC3, 2'b00, 1'b0);
        wait_done(8, 200, d);
        chk("t6_latency", d - acc8_cyc, 100);
        chk("t6_line", int'(rx(8, acc8_cyc, 10)), 16'h0386);

        // Random traffic on both instances, model-checked every cycle
        for (int i = 0; i < 4000; i++) begin
            @(posedge sys_clk); #1;
            en8  = ($urandom_range(0, 2) == 0);
            din8 = 8'($urandom);
            par8 = 2'($urandom);
            st8  = 1'($urandom);
            en7  = ($urandom_range(0, 2) == 0);
            din7 = 7'($urandom);
            par7 = 2'($urandom);
            st7  = 1'($urandom);
            sys_rst_n = ($urandom_range(0, 1499) != 0);
        end
        @(posedge sys_clk); #1;
        en8 = 1'b0; en7 = 1'b0; sys_rst_n = 1'b1;
        repeat (300) @(posedge sys_clk);
        @(negedge sys_clk);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/uart_tx_cfg.md
Name: uart_tx_cfg

Overview:
Parametrised UART transmitter, successor to the fixed 8N1 sender. Adds:
- configurable data width;
- runtime-selectable parity (none/odd/even) and 1 or 2 stop bits;
- a valid/ready handshake in place of rising-edge detect;
- busy/done status.

It sits between byte producers (ID readers, debug dumpers) and the board TX pin.

Parameters:
- CLK_FREQ, 50000000, system clock frequency in Hz.
- UART_BPS, 115200, baud rate. Localparam BPS_CNT = CLK_FREQ/UART_BPS; must be ≥ 2.
- DATA_BITS, 8, data bits per frame. Legal range 5..9.

Ports:
- sys_clk  in  1  system clock.
- sys_rst_n  in  1  reset, synchronous, active-low.
- uart_en  in  1  frame request (valid).
- uart_din  in  DATA_BITS  data to send, LSB first.
- cfg_parity  in  2  parity mode: 00 none, 01 odd, 10 even, 11 treated as none.
- cfg_stop2  in  1  0 = one stop bit, 1 = two stop bits.
- tx_ready  out  1  high when a request can be accepted.
- tx_busy  out  1  high while a frame is on the line.
- tx_done  out  1  one-cycle pulse at the end of the last stop bit.
- uart_txd  out  1  serial output, idle high.

Behaviour:
- Single clock sys_clk. Reset sys_rst_n is synchronous and active-low, sampled only on the sys_clk rising edge.
- Reset values: uart_txd=1, tx_ready=1, tx_busy=0, tx_done=0. State=IDLE, all counters 0.
- tx_ready is combinational: (state==IDLE).
- Accept occurs on a cycle where uart_en && tx_ready. On accept the block latches:
  - uart_din;
  - cfg_parity, cfg_stop2;
  - parity bit: odd = ~^data, even = ^data, over all DATA_BITS bits.
- Config or data changes after accept have no effect on the frame in flight.
- uart_en is level-sensitive. Holding it high sends back-to-back frames; no edge detect is required.
- FSM states: IDLE → START → DATA → PARITY (skipped when parity is none) → STOP → IDLE.
- Bit timing:
  - Each line bit lasts exactly BPS_CNT clocks.
  - The bit-period counter runs 0..BPS_CNT-1 and is cleared on accept.
  - bit_tick asserts when the counter is at BPS_CNT-1 and advances the FSM.
- Data counter counts 0..DATA_BITS-1 and moves to the next state at the tick for bit DATA_BITS-1.
- STOP lasts 1×BPS_CNT or 2×BPS_CNT according to the latched stop2. Stop-bit time is full length; there is no half-stop early exit.
- uart_txd is registered:
  - the start-bit low appears the cycle after accept;
  - the line returns high when the STOP state is entered;
  - the line stays high in IDLE.
- Frame length is (1 + DATA_BITS + P + S) × BPS_CNT clocks, where P = 1 if parity is enabled (else 0) and S = 1 or 2 stop bits.
- tx_done pulses on the final STOP tick, which is the same cycle the FSM returns to IDLE. tx_ready is high on the following cycle.
- Back-to-back timing: accept in the first IDLE cycle. The inter-frame gap is therefore exactly 1 extra clock of idle high.
- tx_busy = (state != IDLE).
- Reset mid-frame: on the first clock with sys_rst_n=0, the frame is aborted, all outputs return to reset values the next edge, and no tx_done is issued.
- Arithmetic widths:
  - bit counter: $clog2(BPS_CNT) bits;
  - data counter: $clog2(DATA_BITS) bits;
  - no wrap is permitted beyond the stated terminal values.

Decomposition:
- Package uart_pkg holds:
  - parity constants PAR_NONE=2'b00, PAR_ODD=2'b01, PAR_EVEN=2'b10;
  - FSM state encoding;
  - the BPS_CNT computation function.
- One sub-module, uart_baud_tick: bit-period counter with sync clear (on accept) and enable (busy), outputting bit_tick.
- Shift/parity logic and the FSM stay in uart_tx_cfg.

Test Plan:
Sim parameters: CLK_FREQ=50000000, UART_BPS=5000000 (BPS_CNT=10).
1. 8N1, din=0x55, uart_en 1-cycle pulse → txd = 0,1,0,1,0,1,0,1,0,1 each 10 clocks. tx_done exactly 100 clocks after accept; tx_ready high 101 clocks after accept.
2. 8E1, din=0xA7 (5 ones) → parity bit=1, frame 110 clocks. Then 8O1 with the same data → parity bit=0.
3. 8O2, din=0x00 → parity=1, two stop bits high, tx_done 120 clocks after accept. Toggling cfg_parity/cfg_stop2 mid-frame changes nothing.
4. uart_en held high, din=0x31 then 0x32 on tx_done → second start bit falls 1 clock after the first frame's tx_done. Both bytes decode correctly on the bench receiver.
5. DATA_BITS=7 instance, din=7'h7F, even parity → 7 data ones, parity=1, frame 100 clocks.
6. sys_rst_n low for 1 clock during data bit 3 → txd=1, tx_busy=0, tx_ready=1 after the edge, no tx_done. A following 0xC3 frame is bit-exact.
